// File: rtl/dfm_pkg.sv
// Shared types for the equal-precision frequency meter gate.
// Optional no-edge timeout is built only when DFM_TIMEOUT_EN is defined.
package dfm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GATE,
        DONE
    } eqp_state_t;

    localparam int DFM_CNT_W_DEF = 32;

endpackage

// File: rtl/eqp_gate_counter_if.sv
// Result handshake bundle: per-channel valid/ack plus held counts and flags.
// master = gate counter, slave = divider/display consumer.
interface eqp_gate_counter_if
    import dfm_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = DFM_CNT_W_DEF
) ();

    logic [CH-1:0]       res_valid;
    logic [CH-1:0]       res_ack;
    logic [CH*CNT_W-1:0] nx_cnt;
    logic [CH*CNT_W-1:0] ns_cnt;
    logic [CH-1:0]       ovf;
    logic [CH-1:0]       err;

    modport master (
        output res_valid,
        output nx_cnt,
        output ns_cnt,
        output ovf,
        output err,
        input  res_ack
    );

    modport slave (
        input  res_valid,
        input  nx_cnt,
        input  ns_cnt,
        input  ovf,
        input  err,
        output res_ack
    );

endinterface

// File: rtl/eqp_channel.sv
// One measurement channel: sync, edge detect, gate FSM, saturating counters.
// DFM_TIMEOUT_EN adds a no-edge abort counter driving err.
module eqp_channel
    import dfm_pkg::*;
#(
    parameter int CNT_W       = DFM_CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             pregate,
    input  logic             pg_rise,
    input  logic             res_ack,
    output logic             realgate,
    output logic             res_valid,
    output logic [CNT_W-1:0] nx_cnt,
    output logic [CNT_W-1:0] ns_cnt,
    output logic             ovf,
    output logic             err
);

    eqp_state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q_d;
    logic                   rise;
    logic                   to_hit;
    logic                   open;
    logic                   abort_arm;
    logic                   ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= '0;
            sync_q_d <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], d_in};
            sync_q_d <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign rise = sync_ff[SYNC_STAGES-1] & ~sync_q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A closing edge wins over a timeout hitting in the same cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pg_rise) state_nxt = ARM;
            ARM: begin
                if (!pregate)    state_nxt = IDLE;
                else if (rise)   state_nxt = GATE;
                else if (to_hit) state_nxt = DONE;
            end
            GATE: begin
                if (rise && !pregate) state_nxt = DONE;
                else if (to_hit)      state_nxt = DONE;
            end
            DONE: if (res_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign open      = (state == ARM) && (state_nxt == GATE);
    assign abort_arm = (state == ARM) && (state_nxt == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx_cnt <= '0;
            ns_cnt <= '0;
            ovf_q  <= 1'b0;
        end else if (open || abort_arm) begin
            nx_cnt <= '0;
            ns_cnt <= '0;
            ovf_q  <= 1'b0;
        end else if (state == GATE) begin
            if (&ns_cnt) ovf_q  <= 1'b1;
            else         ns_cnt <= ns_cnt + 1'b1;
            if (rise) begin
                if (&nx_cnt) ovf_q  <= 1'b1;
                else         nx_cnt <= nx_cnt + 1'b1;
            end
        end
    end

`ifdef DFM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_cnt;
    logic            err_q;

    assign to_hit = ((state == ARM) || (state == GATE)) && !rise &&
                    (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (rise || (state_nxt != state) ||
                !((state == ARM) || (state == GATE)))
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
            if (open)
                err_q <= 1'b0;
            else if (to_hit && (state_nxt == DONE))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYC;
    assign to_hit         = 1'b0;
    assign err            = 1'b0;
`endif

    assign realgate  = (state == GATE);
    assign res_valid = (state == DONE);
    assign ovf       = ovf_q;

endmodule

// File: rtl/eqp_gate_counter.sv
// Multi-channel equal-precision gate: f = f_clk * nx / ns per channel.
// Build with DFM_TIMEOUT_EN to enable the per-channel no-edge abort.
module eqp_gate_counter
    import dfm_pkg::*;
#(
    parameter int CH          = 4,
    parameter int CNT_W       = DFM_CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       d_in,
    input  logic                pregate,
    output logic [CH-1:0]       realgate,
    eqp_gate_counter_if.master  res
);

    logic                pg_q;
    logic                pg_rise;
    logic [CH-1:0]       valid_v;
    logic [CH-1:0]       ovf_v;
    logic [CH-1:0]       err_v;
    logic [CH*CNT_W-1:0] nx_v;
    logic [CH*CNT_W-1:0] ns_v;

    // pregate is already clk-synchronous; one flop is enough for its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pg_q <= 1'b0;
        else        pg_q <= pregate;
    end

    assign pg_rise = pregate & ~pg_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        eqp_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .d_in      (d_in[i]),
            .pregate   (pregate),
            .pg_rise   (pg_rise),
            .res_ack   (res.res_ack[i]),
            .realgate  (realgate[i]),
            .res_valid (valid_v[i]),
            .nx_cnt    (nx_v[i*CNT_W +: CNT_W]),
            .ns_cnt    (ns_v[i*CNT_W +: CNT_W]),
            .ovf       (ovf_v[i]),
            .err       (err_v[i])
        );
    end

    assign res.res_valid = valid_v;
    assign res.nx_cnt    = nx_v;
    assign res.ns_cnt    = ns_v;
    assign res.ovf       = ovf_v;
    assign res.err       = err_v;

endmodule
